axi_arbiter_nx1: RTL

Parametrised N-master to 1-slave AXI arbiter. It replaces the fixed two-port instruction/data bus mux between the per-cache AXI converters and the core's external memory bus. Read and write paths are arbitrated independently, with round-robin or fixed priority. Each path keeps a burst-locked grant until the burst completes, and a beat counter generates `m_w_last` and flags length mismatches.

---
 rtl/axi_arbiter_nx1.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_arbiter_nx1.sv
// N-master to 1-slave AXI arbiter with independent read/write paths, burst-locked grants
// and a beat counter that generates m_w_last and flags burst-length mismatches.
module axi_arbiter_nx1 #(
    parameter int NM         = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 4,
    parameter int RR         = 1
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic [NM-1:0]                s_ar_valid,
    output logic [NM-1:0]                s_ar_ready,
    input  logic [NM*ADDR_WIDTH-1:0]     s_ar_addr,
    input  logic [NM*ID_WIDTH-1:0]       s_ar_id,
    input  logic [NM*LEN_WIDTH-1:0]      s_ar_len,
    input  logic [NM*3-1:0]              s_ar_size,
    input  logic [NM*2-1:0]              s_ar_burst,
    output logic [NM-1:0]                s_r_valid,
    output logic [NM-1:0]                s_r_last,
    input  logic [NM-1:0]                s_r_ready,
    output logic [NM*DATA_WIDTH-1:0]     s_r_data,
    output logic [NM*ID_WIDTH-1:0]       s_r_id,
    output logic [NM*2-1:0]              s_r_resp,

    input  logic [NM-1:0]                s_aw_valid,
    output logic [NM-1:0]                s_aw_ready,
    input  logic [NM*ADDR_WIDTH-1:0]     s_aw_addr,
    input  logic [NM*ID_WIDTH-1:0]       s_aw_id,
    input  logic [NM*LEN_WIDTH-1:0]      s_aw_len,
    input  logic [NM*3-1:0]              s_aw_size,
    input  logic [NM*2-1:0]              s_aw_burst,
    input  logic [NM-1:0]                s_w_valid,
    input  logic [NM-1:0]                s_w_last,
    output logic [NM-1:0]                s_w_ready,
    input  logic [NM*DATA_WIDTH-1:0]     s_w_data,
    input  logic [NM*(DATA_WIDTH/8)-1:0] s_w_strb,
    output logic [NM-1:0]                s_b_valid,
    input  logic [NM-1:0]                s_b_ready,
    output logic [ID_WIDTH-1:0]          s_b_id,
    output logic [1:0]                   s_b_resp,

    output logic                         m_ar_valid,
    input  logic                         m_ar_ready,
    output logic [ADDR_WIDTH-1:0]        m_ar_addr,
    output logic [ID_WIDTH-1:0]          m_ar_id,
    output logic [LEN_WIDTH-1:0]         m_ar_len,
    output logic [2:0]                   m_ar_size,
    output logic [1:0]                   m_ar_burst,
    input  logic                         m_r_valid,
    input  logic                         m_r_last,
    output logic                         m_r_ready,
    input  logic [DATA_WIDTH-1:0]        m_r_data,
    input  logic [ID_WIDTH-1:0]          m_r_id,
    input  logic [1:0]                   m_r_resp,

    output logic                         m_aw_valid,
    input  logic                         m_aw_ready,
    output logic [ADDR_WIDTH-1:0]        m_aw_addr,
    output logic [ID_WIDTH-1:0]          m_aw_id,
    output logic [LEN_WIDTH-1:0]         m_aw_len,
    output logic [2:0]                   m_aw_size,
    output logic [1:0]                   m_aw_burst,
    output logic                         m_w_valid,
    output logic                         m_w_last,
    input  logic                         m_w_ready,
    output logic [DATA_WIDTH-1:0]        m_w_data,
    output logic [DATA_WIDTH/8-1:0]      m_w_strb,
    input  logic                         m_b_valid,
    output logic                         m_b_ready,
    input  logic [ID_WIDTH-1:0]          m_b_id,
    input  logic [1:0]                   m_b_resp,

    output logic                         err_o
);

    localparam int GW = (NM > 1) ? $clog2(NM) : 1;
    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

    r_state_t             r_state, r_next;
    w_state_t             w_state, w_next;
    logic [GW-1:0]        rgnt, wgnt, rlast, wlast;
    logic [LEN_WIDTH-1:0] rcnt, rcnt_max, wcnt, wcnt_max;
    logic                 r_beat, w_beat, b_done, sel_w_last;

    // Smallest rotational distance from last+1 wins; with RR=0 the distance is just the index.
    function automatic logic [GW-1:0] pick(input logic [NM-1:0] req, input logic [GW-1:0] last);
        logic [GW-1:0] win;
        int            best;
        int            d;
        win  = '0;
        best = NM;
        for (int j = 0; j < NM; j++) begin
            d = (RR != 0) ? ((j - int'(last) - 1 + 2 * NM) % NM) : j;
            if (req[j] && d < best) begin
                best = d;
                win  = GW'(j);
            end
        end
        return win;
    endfunction

    assign r_beat = (r_state == R_DATA) && m_r_valid && m_r_ready;
    assign w_beat = (w_state == W_DATA) && m_w_valid && m_w_ready;
    assign b_done = (w_state == W_RESP) && m_b_valid && m_b_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
        end else begin
            r_state <= r_next;
            w_state <= w_next;
        end
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (|s_ar_valid) r_next = R_ADDR;
            R_ADDR:  if (m_ar_ready) r_next = R_DATA;
            R_DATA:  if (r_beat && m_r_last) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (|s_aw_valid) w_next = W_ADDR;
            W_ADDR:  if (m_aw_ready) w_next = W_DATA;
            W_DATA:  if (w_beat && m_w_last) w_next = W_RESP;
            W_RESP:  if (b_done) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Grants, beat counters and the sticky length-mismatch flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgnt     <= '0;
            wgnt     <= '0;
            rlast    <= GW'(NM - 1);
            wlast    <= GW'(NM - 1);
            rcnt     <= '0;
            rcnt_max <= '0;
            wcnt     <= '0;
            wcnt_max <= '0;
            err_o    <= 1'b0;
        end else begin
            if (r_state == R_IDLE && |s_ar_valid) rgnt <= pick(s_ar_valid, rlast);
            if (r_state == R_ADDR && m_ar_ready) begin
                rcnt_max <= m_ar_len;
                rcnt     <= '0;
            end
            if (r_beat) begin
                rcnt <= rcnt + 1'b1;
                if (m_r_last) rlast <= rgnt;
            end
            if (w_state == W_IDLE && |s_aw_valid) wgnt <= pick(s_aw_valid, wlast);
            if (w_state == W_ADDR && m_aw_ready) begin
                wcnt_max <= m_aw_len;
                wcnt     <= '0;
            end
            if (w_beat) wcnt <= wcnt + 1'b1;
            if (b_done) wlast <= wgnt;
            if ((r_beat && (m_r_last != (rcnt == rcnt_max))) || (w_beat && (sel_w_last != m_w_last)))
                err_o <= 1'b1;
        end
    end

    always_comb begin
        m_ar_valid = 1'b0;
        m_ar_addr  = '0;
        m_ar_id    = '0;
        m_ar_len   = '0;
        m_ar_size  = '0;
        m_ar_burst = '0;
        s_ar_ready = '0;
        s_r_valid  = '0;
        s_r_last   = '0;
        m_r_ready  = 1'b0;
        for (int i = 0; i < NM; i++) begin
            if (rgnt == GW'(i)) begin
                if (r_state == R_ADDR) begin
                    m_ar_valid    = 1'b1;
                    m_ar_addr     = s_ar_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    m_ar_id       = s_ar_id[i*ID_WIDTH +: ID_WIDTH];
                    m_ar_len      = s_ar_len[i*LEN_WIDTH +: LEN_WIDTH];
                    m_ar_size     = s_ar_size[i*3 +: 3];
                    m_ar_burst    = s_ar_burst[i*2 +: 2];
                    s_ar_ready[i] = m_ar_ready;
                end
                if (r_state == R_DATA) begin
                    s_r_valid[i] = m_r_valid;
                    s_r_last[i]  = m_r_last;
                    m_r_ready    = s_r_ready[i];
                end
            end
        end
    end

    // The master's own last flag is only compared against the generated one, never forwarded.
    always_comb begin
        m_aw_valid = 1'b0;
        m_aw_addr  = '0;
        m_aw_id    = '0;
        m_aw_len   = '0;
        m_aw_size  = '0;
        m_aw_burst = '0;
        s_aw_ready = '0;
        m_w_valid  = 1'b0;
        m_w_last   = 1'b0;
        m_w_data   = '0;
        m_w_strb   = '0;
        s_w_ready  = '0;
        sel_w_last = 1'b0;
        s_b_valid  = '0;
        m_b_ready  = 1'b0;
        for (int i = 0; i < NM; i++) begin
            if (wgnt == GW'(i)) begin
                if (w_state == W_ADDR) begin
                    m_aw_valid    = 1'b1;
                    m_aw_addr     = s_aw_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    m_aw_id       = s_aw_id[i*ID_WIDTH +: ID_WIDTH];
                    m_aw_len      = s_aw_len[i*LEN_WIDTH +: LEN_WIDTH];
                    m_aw_size     = s_aw_size[i*3 +: 3];
                    m_aw_burst    = s_aw_burst[i*2 +: 2];
                    s_aw_ready[i] = m_aw_ready;
                end
                if (w_state == W_DATA) begin
                    m_w_valid    = s_w_valid[i];
                    m_w_last     = (wcnt == wcnt_max);
                    m_w_data     = s_w_data[i*DATA_WIDTH +: DATA_WIDTH];
                    m_w_strb     = s_w_strb[i*SW +: SW];
                    s_w_ready[i] = m_w_ready;
                    sel_w_last   = s_w_last[i];
                end
                if (w_state == W_RESP) begin
                    s_b_valid[i] = m_b_valid;
                    m_b_ready    = s_b_ready[i];
                end
            end
        end
    end

    assign s_r_data = {NM{m_r_data}};
    assign s_r_id   = {NM{m_r_id}};
    assign s_r_resp = {NM{m_r_resp}};
    assign s_b_id   = m_b_id;
    assign s_b_resp = m_b_resp;

endmodule
